// File: rtl/dip_switch_regs.sv
// Live DIP-switch word for the game CPU. Host writes land in a staging register
// and are applied only while the CPU is held in reset or on a vblank rising edge.
module dip_switch_regs #(
    parameter logic [31:0] DIP_ADDR      = 32'h0000_F000,
    parameter logic [15:0] DIP_DEFAULT   = 16'h9CF7,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        bridge_wr,
    input  logic        bridge_rd,
    input  logic [31:0] bridge_addr,
    input  logic [31:0] bridge_wr_data,
    output logic [31:0] bridge_rd_data,
    input  logic        vblank,
    input  logic        cpu_in_reset,
    output logic [15:0] dip_out,
    output logic        dip_pending,
    output logic        dip_changed
);

    localparam logic [31:0] CTL_ADDR    = DIP_ADDR + 32'd4;
    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);

    logic [15:0] staged;
    logic        pending;
    logic [15:0] hold;
    logic        vblank_q;

    logic wr_dip;
    logic wr_ctl;
    logic vblank_rise;
    logic commit;

    assign wr_dip      = bridge_wr && (bridge_addr == DIP_ADDR);
    assign wr_ctl      = bridge_wr && (bridge_addr == CTL_ADDR);
    assign vblank_rise = vblank & ~vblank_q;
    assign commit      = pending & (hold == 16'd0) & (cpu_in_reset | vblank_rise);
    assign dip_pending = pending;

    // A host write or default-load in the commit cycle re-arms pending so the
    // newer value is applied at the next safe point; a cancel does not.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            staged  <= DIP_DEFAULT;
            pending <= 1'b0;
        end else begin
            if (wr_dip) begin
                staged  <= bridge_wr_data[15:0];
                pending <= 1'b1;
            end else if (wr_ctl && bridge_wr_data[0]) begin
                staged  <= DIP_DEFAULT;
                pending <= 1'b1;
            end else if (wr_ctl && bridge_wr_data[1]) begin
                pending <= 1'b0;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dip_out     <= DIP_DEFAULT;
            dip_changed <= 1'b0;
            hold        <= 16'd0;
            vblank_q    <= 1'b0;
        end else begin
            vblank_q    <= vblank;
            dip_changed <= commit;
            if (commit) begin
                dip_out <= staged;
                hold    <= SETTLE_LOAD;
            end else if (hold != 16'd0) begin
                hold <= hold - 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bridge_rd_data <= 32'h0;
        end else if (bridge_rd) begin
            if (bridge_addr == DIP_ADDR) begin
                bridge_rd_data <= {16'h0, staged};
            end else if (bridge_addr == CTL_ADDR) begin
                bridge_rd_data <= {29'h0, (hold != 16'd0), cpu_in_reset, pending};
            end else begin
                bridge_rd_data <= 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dip_switch_regs.sv
// Directed bench for dip_switch_regs: a cycle table for the basic flow, then
// hand-written sequences for hold-off, same-cycle races, control and reset.
module tb_dip_switch_regs;

    localparam logic [31:0] DIP = 32'h0000_F000;
    localparam logic [31:0] CTL = 32'h0000_F004;
    localparam logic [31:0] OTH = 32'h0000_F008;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        bridge_wr = 1'b0;
    logic        bridge_rd = 1'b0;
    logic [31:0] bridge_addr = 32'h0;
    logic [31:0] bridge_wr_data = 32'h0;
    logic [31:0] bridge_rd_data;
    logic        vblank = 1'b0;
    logic        cpu_in_reset = 1'b0;
    logic [15:0] dip_out;
    logic        dip_pending;
    logic        dip_changed;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int          pre_idle;
        logic        cpu_rst;
        logic        vb;
        logic        wr;
        logic        rd;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] exp_dip;
        logic        exp_pend;
        logic        exp_chg;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    dip_switch_regs dut (
        .clk            (clk),
        .reset          (reset),
        .bridge_wr      (bridge_wr),
        .bridge_rd      (bridge_rd),
        .bridge_addr    (bridge_addr),
        .bridge_wr_data (bridge_wr_data),
        .bridge_rd_data (bridge_rd_data),
        .vblank         (vblank),
        .cpu_in_reset   (cpu_in_reset),
        .dip_out        (dip_out),
        .dip_pending    (dip_pending),
        .dip_changed    (dip_changed)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(int pre, logic cpu, logic vb, logic wr, logic rd,
                                logic [31:0] addr, logic [31:0] wdata,
                                logic [15:0] edip, logic epend, logic echg,
                                logic [31:0] erd);
        vec_t v;
        v.pre_idle = pre; v.cpu_rst = cpu; v.vb = vb; v.wr = wr; v.rd = rd;
        v.addr = addr; v.wdata = wdata;
        v.exp_dip = edip; v.exp_pend = epend; v.exp_chg = echg; v.exp_rd = erd;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bridge_wr = 1'b1; bridge_addr = addr; bridge_wr_data = data;
        tick();
        bridge_wr = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr);
        bridge_rd = 1'b1; bridge_addr = addr;
        tick();
        bridge_rd = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        cpu_in_reset = v.cpu_rst;
        vblank = 1'b0;
        for (int k = 0; k < v.pre_idle; k++) tick();
        vblank = v.vb; bridge_wr = v.wr; bridge_rd = v.rd;
        bridge_addr = v.addr; bridge_wr_data = v.wdata;
        tick();
        bridge_wr = 1'b0; bridge_rd = 1'b0;
    endtask

    initial begin
        // pre_idle, cpu, vb, wr, rd, addr, wdata, dip, pend, chg, rd_data
        vecs.push_back(mk(0, 0, 0, 0, 1, CTL, 0, 16'h9CF7, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, DIP, 0, 16'h9CF7, 0, 0, 32'h9CF7));
        vecs.push_back(mk(0, 1, 0, 1, 0, DIP, 32'h1234, 16'h9CF7, 1, 0, 32'h9CF7));
        vecs.push_back(mk(0, 1, 0, 0, 0, DIP, 0, 16'h1234, 0, 1, 32'h9CF7));
        vecs.push_back(mk(0, 1, 0, 0, 1, CTL, 0, 16'h1234, 0, 0, 32'h6));
        vecs.push_back(mk(14, 1, 0, 0, 1, CTL, 0, 16'h1234, 0, 0, 32'h6));
        vecs.push_back(mk(0, 1, 0, 0, 1, CTL, 0, 16'h1234, 0, 0, 32'h2));
        vecs.push_back(mk(0, 0, 0, 1, 0, DIP, 32'hABCD, 16'h1234, 1, 0, 32'h2));
        vecs.push_back(mk(3, 0, 0, 0, 1, CTL, 0, 16'h1234, 1, 0, 32'h1));
        vecs.push_back(mk(0, 0, 1, 0, 0, DIP, 0, 16'hABCD, 0, 1, 32'h1));
        vecs.push_back(mk(0, 0, 1, 0, 1, CTL, 0, 16'hABCD, 0, 0, 32'h4));
        vecs.push_back(mk(0, 0, 0, 1, 0, OTH, 32'h1, 16'hABCD, 0, 0, 32'h4));
        vecs.push_back(mk(0, 0, 0, 0, 1, OTH, 0, 16'hABCD, 0, 0, 32'h0));
        vecs.push_back(mk(0, 0, 0, 0, 1, DIP, 0, 16'hABCD, 0, 0, 32'hABCD));

        idle(3);
        reset = 1'b0;
        checkOutput("reset_dip", 32'(dip_out), 32'h9CF7);
        checkOutput("reset_pend", 32'(dip_pending), 32'h0);
        checkOutput("reset_chg", 32'(dip_changed), 32'h0);
        checkOutput("reset_rd", bridge_rd_data, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("row%0d_dip", i), 32'(dip_out), 32'(vecs[i].exp_dip));
            checkOutput($sformatf("row%0d_pend", i), 32'(dip_pending), 32'(vecs[i].exp_pend));
            checkOutput($sformatf("row%0d_chg", i), 32'(dip_changed), 32'(vecs[i].exp_chg));
            checkOutput($sformatf("row%0d_rd", i), bridge_rd_data, vecs[i].exp_rd);
        end

        // A vblank rise during hold-off is dropped; the next rise applies.
        vblank = 1'b0; cpu_in_reset = 1'b0;
        idle(20);
        bus_write(DIP, 32'h1111);
        vblank = 1'b1; tick(); vblank = 1'b0;
        checkOutput("hold_first_dip", 32'(dip_out), 32'h1111);
        checkOutput("hold_first_chg", 32'(dip_changed), 32'h1);
        bus_write(DIP, 32'h2222);
        checkOutput("hold_pend", 32'(dip_pending), 32'h1);
        idle(4);
        vblank = 1'b1; tick(); vblank = 1'b0;
        checkOutput("hold_lost_dip", 32'(dip_out), 32'h1111);
        checkOutput("hold_lost_pend", 32'(dip_pending), 32'h1);
        idle(15);
        checkOutput("hold_wait_dip", 32'(dip_out), 32'h1111);
        checkOutput("hold_wait_pend", 32'(dip_pending), 32'h1);
        vblank = 1'b1; tick(); vblank = 1'b0;
        checkOutput("hold_apply_dip", 32'(dip_out), 32'h2222);
        checkOutput("hold_apply_chg", 32'(dip_changed), 32'h1);
        tick();
        checkOutput("hold_chg_single", 32'(dip_changed), 32'h0);

        // Write landing in the commit cycle: old staged applies, new stays pending.
        idle(20);
        bus_write(DIP, 32'h4444);
        bridge_wr = 1'b1; bridge_addr = DIP; bridge_wr_data = 32'h5555; vblank = 1'b1;
        tick();
        bridge_wr = 1'b0; vblank = 1'b0;
        checkOutput("race_dip", 32'(dip_out), 32'h4444);
        checkOutput("race_pend", 32'(dip_pending), 32'h1);
        checkOutput("race_chg", 32'(dip_changed), 32'h1);
        bus_read(DIP);
        checkOutput("race_staged", bridge_rd_data, 32'h5555);
        idle(20);
        checkOutput("race_wait_dip", 32'(dip_out), 32'h4444);
        cpu_in_reset = 1'b1; tick(); cpu_in_reset = 1'b0;
        checkOutput("race_apply_dip", 32'(dip_out), 32'h5555);
        checkOutput("race_apply_pend", 32'(dip_pending), 32'h0);

        // Control register: cancel, default load, both bits set.
        idle(20);
        bus_write(DIP, 32'h0F0F);
        checkOutput("ctl_stage_pend", 32'(dip_pending), 32'h1);
        bus_write(CTL, 32'h2);
        checkOutput("ctl_cancel_pend", 32'(dip_pending), 32'h0);
        vblank = 1'b1; tick(); vblank = 1'b0;
        cpu_in_reset = 1'b1; tick(); cpu_in_reset = 1'b0;
        checkOutput("ctl_cancel_dip", 32'(dip_out), 32'h5555);
        checkOutput("ctl_cancel_chg", 32'(dip_changed), 32'h0);
        bus_read(DIP);
        checkOutput("ctl_cancel_staged", bridge_rd_data, 32'h0F0F);
        bus_write(CTL, 32'h1);
        checkOutput("ctl_default_pend", 32'(dip_pending), 32'h1);
        bus_read(DIP);
        checkOutput("ctl_default_staged", bridge_rd_data, 32'h9CF7);
        vblank = 1'b1; tick(); vblank = 1'b0;
        checkOutput("ctl_default_dip", 32'(dip_out), 32'h9CF7);
        checkOutput("ctl_default_chg", 32'(dip_changed), 32'h1);
        checkOutput("ctl_default_clr", 32'(dip_pending), 32'h0);
        bus_write(DIP, 32'h1234);
        bus_write(CTL, 32'h3);
        checkOutput("ctl_both_pend", 32'(dip_pending), 32'h1);
        bus_read(DIP);
        checkOutput("ctl_both_staged", bridge_rd_data, 32'h9CF7);

        // Asynchronous reset in the middle of a hold-off.
        bus_write(DIP, 32'h7777);
        bus_read(CTL);
        checkOutput("rst_pre_status", bridge_rd_data, 32'h5);
        bus_read(DIP);
        checkOutput("rst_pre_staged", bridge_rd_data, 32'h7777);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("rst_async_dip", 32'(dip_out), 32'h9CF7);
        checkOutput("rst_async_pend", 32'(dip_pending), 32'h0);
        checkOutput("rst_async_rd", bridge_rd_data, 32'h0);
        tick();
        reset = 1'b0;
        bus_read(DIP);
        checkOutput("rst_staged", bridge_rd_data, 32'h9CF7);
        bus_read(CTL);
        checkOutput("rst_status", bridge_rd_data, 32'h0);
        checkOutput("rst_chg", 32'(dip_changed), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
